// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video output path.
//   - Default panel timing (800x480 active, porches and sync widths)
//   - rgb_t : packed 8:8:8 pixel
//   - state_t : timing generator control state
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int HDISP_DEF  = 800;
    localparam int VDISP_DEF  = 480;
    localparam int HFP_DEF    = 40;
    localparam int HPULSE_DEF = 48;
    localparam int HBP_DEF    = 40;
    localparam int VFP_DEF    = 13;
    localparam int VPULSE_DEF = 3;
    localparam int VBP_DEF    = 29;
    localparam int RGB_W_DEF  = 24;

    typedef logic [23:0] rgb_t;

    typedef enum logic [0:0] {
        WAIT_FULL = 1'b0,
        RUN       = 1'b1
    } state_t;

endpackage

// File: rtl/timing_counter.sv
// -----------------------------------------------------------------------------
// timing_counter
// Pair of wrap counters forming the raster position.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : advance one position per cycle when high
//   hcnt       : 0 .. HTOTAL-1, wraps to 0
//   vcnt       : 0 .. VTOTAL-1, steps on each hcnt wrap
//   line_end   : hcnt is at its last value this cycle
//   frame_end  : last position of the frame this cycle
// -----------------------------------------------------------------------------
module timing_counter #(
    parameter int HTOTAL = 928,
    parameter int VTOTAL = 525
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [$clog2(HTOTAL)-1:0] hcnt,
    output logic [$clog2(VTOTAL)-1:0] vcnt,
    output logic                      line_end,
    output logic                      frame_end
);

    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);
    localparam logic [HW-1:0] HLAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] VLAST = VW'(VTOTAL - 1);

    assign line_end  = (hcnt == HLAST);
    assign frame_end = line_end && (vcnt == VLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= frame_end ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Display timing generator. Waits after reset until the upstream show-ahead
// pixel FIFO is full, then free-runs the raster, popping one pixel per active
// cycle and driving registered video outputs.
//   pixel_clk, pixel_rst : clock, asynchronous active-high reset
//   fifo_rdata           : FIFO head word (show-ahead)
//   fifo_rempty          : FIFO empty
//   fifo_rfull           : FIFO full, starts the raster once
//   fifo_rinc            : pop strobe (combinational from registered state)
//   vga_hs, vga_vs       : active-low syncs
//   vga_blank            : 1 during active video
//   vga_rgb              : pixel data, 0 in blanking or on underflow
//   pixel_x, pixel_y     : coordinates of the pixel on vga_rgb, 0 in blanking
//   frame_start          : one-cycle pulse with pixel (0,0)
//   underflow            : sticky, FIFO was empty for an active pixel
// -----------------------------------------------------------------------------
module vga_timing_gen
    import video_pkg::*;
#(
    parameter int HDISP  = HDISP_DEF,
    parameter int VDISP  = VDISP_DEF,
    parameter int HFP    = HFP_DEF,
    parameter int HPULSE = HPULSE_DEF,
    parameter int HBP    = HBP_DEF,
    parameter int VFP    = VFP_DEF,
    parameter int VPULSE = VPULSE_DEF,
    parameter int VBP    = VBP_DEF,
    parameter int RGB_W  = RGB_W_DEF
) (
    input  logic                     pixel_clk,
    input  logic                     pixel_rst,
    input  logic [RGB_W-1:0]         fifo_rdata,
    input  logic                     fifo_rempty,
    input  logic                     fifo_rfull,
    output logic                     fifo_rinc,
    output logic                     vga_hs,
    output logic                     vga_vs,
    output logic                     vga_blank,
    output logic [RGB_W-1:0]         vga_rgb,
    output logic [$clog2(HDISP)-1:0] pixel_x,
    output logic [$clog2(VDISP)-1:0] pixel_y,
    output logic                     frame_start,
    output logic                     underflow
);

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    localparam logic [HW-1:0] HDISP_C  = HW'(HDISP);
    localparam logic [HW-1:0] HS_START = HW'(HDISP + HFP);
    localparam logic [HW-1:0] HS_END   = HW'(HDISP + HFP + HPULSE);
    localparam logic [VW-1:0] VDISP_C  = VW'(VDISP);
    localparam logic [VW-1:0] VS_START = VW'(VDISP + VFP);
    localparam logic [VW-1:0] VS_END   = VW'(VDISP + VFP + VPULSE);

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          line_end;
    logic          frame_end;

    logic          run_p0;
    logic          active_p0;
    logic          hsync_p0;
    logic          vact_p0;
    logic          vsync_p0;
    logic          origin_p0;
    logic [VW-1:0] vnext_p0;

    timing_counter #(
        .HTOTAL (HTOTAL),
        .VTOTAL (VTOTAL)
    ) u_cnt (
        .clk       (pixel_clk),
        .rst       (pixel_rst),
        .en        (run_p0),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // ---- stage p0: decode of the current raster position ----
    assign run_p0    = (state == RUN);
    assign hsync_p0  = (hcnt >= HS_START) && (hcnt < HS_END);
    assign active_p0 = run_p0 && (hcnt < HDISP_C) && vact_p0;
    assign fifo_rinc = active_p0 && !fifo_rempty;
    assign vnext_p0  = frame_end ? '0 : vcnt + 1'b1;

    // Once running, full is never looked at again; only reset returns here.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= WAIT_FULL;
        end else if (state == WAIT_FULL && fifo_rfull) begin
            state <= RUN;
        end
    end

    // Vertical region flags and the (0,0) marker are decoded one line (or
    // frame) ahead so the per-cycle path only compares hcnt.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            vact_p0   <= 1'b1;
            vsync_p0  <= 1'b0;
            origin_p0 <= 1'b1;
        end else if (run_p0) begin
            origin_p0 <= frame_end;
            if (line_end) begin
                vact_p0  <= (vnext_p0 < VDISP_C);
                vsync_p0 <= (vnext_p0 >= VS_START) && (vnext_p0 < VS_END);
            end
        end
    end

    // ---- stage p1: registered video outputs ----
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank   <= 1'b0;
            vga_rgb     <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            vga_hs      <= !(run_p0 && hsync_p0);
            vga_vs      <= !(run_p0 && vsync_p0);
            vga_blank   <= active_p0;
            vga_rgb     <= fifo_rinc ? fifo_rdata : '0;
            pixel_x     <= active_p0 ? hcnt[XW-1:0] : '0;
            pixel_y     <= active_p0 ? vcnt[YW-1:0] : '0;
            frame_start <= active_p0 && origin_p0;
            underflow   <= underflow || (active_p0 && fifo_rempty);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen at 160x90 (HTOTAL 288, VTOTAL 135).
// A FIFO model returns incrementing data; each task drives one scenario and
// checks the outputs against positions tracked by the bench.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HDISP  = 160;
    localparam int VDISP  = 90;
    localparam int HTOTAL = 288;
    localparam int VTOTAL = 135;
    localparam int FRAME  = HTOTAL * VTOTAL;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic [23:0] fifo_rdata = 24'd0;
    logic        fifo_rempty = 1'b0;
    logic        fifo_rfull = 1'b0;
    logic        fifo_rinc;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    logic [23:0] vga_rgb;
    logic [7:0]  pixel_x;
    logic [6:0]  pixel_y;
    logic        frame_start;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rfull  (fifo_rfull),
        .fifo_rinc   (fifo_rinc),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank   (vga_blank),
        .vga_rgb     (vga_rgb),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    // One clock: sample the pop strobe before the edge, advance the FIFO head
    // after the edge if a pop happened. Outputs are stable on return.
    task automatic step(output logic wp);
        @(negedge pixel_clk);
        wp = fifo_rinc;
        @(posedge pixel_clk);
        #1;
        if (wp) fifo_rdata = fifo_rdata + 24'd1;
    endtask

    task automatic test_reset();
        logic wp;
        int   bad_pop;
        int   bad_sync;
        repeat (3) @(posedge pixel_clk);
        #1;
        n_checks++; if (vga_hs !== 1'b1)      begin n_fail++; $display("FAIL reset_hs: got %b, expected 1", vga_hs); end
        n_checks++; if (vga_vs !== 1'b1)      begin n_fail++; $display("FAIL reset_vs: got %b, expected 1", vga_vs); end
        n_checks++; if (vga_blank !== 1'b0)   begin n_fail++; $display("FAIL reset_blank: got %b, expected 0", vga_blank); end
        n_checks++; if (vga_rgb !== 24'd0)    begin n_fail++; $display("FAIL reset_rgb: got %0h, expected 0", vga_rgb); end
        n_checks++; if (pixel_x !== 8'd0)     begin n_fail++; $display("FAIL reset_x: got %0d, expected 0", pixel_x); end
        n_checks++; if (pixel_y !== 7'd0)     begin n_fail++; $display("FAIL reset_y: got %0d, expected 0", pixel_y); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b, expected 0", frame_start); end
        n_checks++; if (underflow !== 1'b0)   begin n_fail++; $display("FAIL reset_uf: got %b, expected 0", underflow); end
        n_checks++; if (fifo_rinc !== 1'b0)   begin n_fail++; $display("FAIL reset_rinc: got %b, expected 0", fifo_rinc); end
        pixel_rst = 1'b0;
        bad_pop  = 0;
        bad_sync = 0;
        for (int i = 0; i < 1000; i++) begin
            step(wp);
            if (wp !== 1'b0) bad_pop++;
            if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank !== 1'b0) bad_sync++;
        end
        n_checks++; if (bad_pop != 0)  begin n_fail++; $display("FAIL wait_full_pops: %0d cycles popped, expected 0", bad_pop); end
        n_checks++; if (bad_sync != 0) begin n_fail++; $display("FAIL wait_full_idle: %0d cycles not idle, expected 0", bad_sync); end
    endtask

    task automatic test_full_frame();
        logic        wp, act, ehs, evs, efs, prev_hs;
        logic [23:0] erg;
        logic [7:0]  epx;
        logic [6:0]  epy;
        int x, y, pops, fall_last, nfall;
        int e_rinc, e_hs, e_vs, e_blank, e_px, e_py, e_fs, e_rgb, e_uf, e_pops, e_per;
        int vs_low, vs_first, fs_cnt, rgb_first;
        e_rinc = 0; e_hs = 0; e_vs = 0; e_blank = 0; e_px = 0; e_py = 0;
        e_fs = 0; e_rgb = 0; e_uf = 0; e_pops = 0; e_per = 0;
        pops = 0; fall_last = -1; nfall = 0; vs_low = 0; vs_first = -1;
        fs_cnt = 0; rgb_first = -1; prev_hs = 1'b1;
        // full starts the raster; dropping it afterwards must not matter
        fifo_rfull = 1'b1;
        step(wp);
        fifo_rfull = 1'b0;
        for (int t = 0; t < FRAME; t++) begin
            x = t % HTOTAL;
            y = t / HTOTAL;
            act = (x < HDISP) && (y < VDISP);
            ehs = !((x >= 200) && (x < 248));
            evs = !((y >= 103) && (y < 106));
            efs = (x == 0) && (y == 0);
            erg = act ? 24'(y * HDISP + x) : 24'd0;
            epx = act ? 8'(x) : 8'd0;
            epy = act ? 7'(y) : 7'd0;
            fifo_rempty = 1'b0;
            step(wp);
            if (wp !== act)          e_rinc++;
            if (vga_hs !== ehs)      e_hs++;
            if (vga_vs !== evs)      e_vs++;
            if (vga_blank !== act)   e_blank++;
            if (pixel_x !== epx)     e_px++;
            if (pixel_y !== epy)     e_py++;
            if (frame_start !== efs) e_fs++;
            if (underflow !== 1'b0)  e_uf++;
            if (vga_rgb !== erg) begin
                e_rgb++;
                if (rgb_first < 0) rgb_first = t;
            end
            if (wp) pops++;
            if (x == HTOTAL - 1) begin
                if (pops != ((y < VDISP) ? HDISP : 0)) e_pops++;
                pops = 0;
            end
            if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
                if (fall_last >= 0 && (t - fall_last) != HTOTAL) e_per++;
                fall_last = t;
                nfall++;
            end
            prev_hs = vga_hs;
            if (vga_vs === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = t;
            end
            if (frame_start === 1'b1) fs_cnt++;
        end
        n_checks++; if (e_rinc != 0)  begin n_fail++; $display("FAIL frame_rinc: %0d wrong cycles, expected 0", e_rinc); end
        n_checks++; if (e_hs != 0)    begin n_fail++; $display("FAIL frame_hs: %0d wrong cycles, expected 0", e_hs); end
        n_checks++; if (e_vs != 0)    begin n_fail++; $display("FAIL frame_vs: %0d wrong cycles, expected 0", e_vs); end
        n_checks++; if (e_blank != 0) begin n_fail++; $display("FAIL frame_blank: %0d wrong cycles, expected 0", e_blank); end
        n_checks++; if (e_px != 0)    begin n_fail++; $display("FAIL frame_x: %0d wrong cycles, expected 0", e_px); end
        n_checks++; if (e_py != 0)    begin n_fail++; $display("FAIL frame_y: %0d wrong cycles, expected 0", e_py); end
        n_checks++; if (e_fs != 0)    begin n_fail++; $display("FAIL frame_start_pos: %0d wrong cycles, expected 0", e_fs); end
        n_checks++; if (e_uf != 0)    begin n_fail++; $display("FAIL frame_underflow: %0d cycles set, expected 0", e_uf); end
        n_checks++; if (e_rgb != 0)   begin n_fail++; $display("FAIL frame_rgb: %0d wrong pixels (first t=%0d), expected 0", e_rgb, rgb_first); end
        n_checks++; if (e_pops != 0)  begin n_fail++; $display("FAIL line_pops: %0d lines with wrong pop count, expected 0", e_pops); end
        n_checks++; if (e_per != 0 || nfall != VTOTAL) begin n_fail++; $display("FAIL line_period: %0d bad periods, %0d hs pulses, expected 0 and %0d", e_per, nfall, VTOTAL); end
        n_checks++; if (vs_low != 3 * HTOTAL) begin n_fail++; $display("FAIL vs_width: got %0d cycles, expected %0d", vs_low, 3 * HTOTAL); end
        n_checks++; if (vs_first != 103 * HTOTAL) begin n_fail++; $display("FAIL vs_start: got t=%0d, expected %0d", vs_first, 103 * HTOTAL); end
        n_checks++; if (fs_cnt != 1)  begin n_fail++; $display("FAIL frame_start_count: got %0d, expected 1", fs_cnt); end
    endtask

    // Second frame up to raster (100,40) with three empty-FIFO pixels on line 5.
    task automatic test_underflow();
        logic        wp, act, hole, ehs, efs, euf;
        logic [23:0] erg;
        int x, y, pops, fs_t;
        int e_rinc, e_hs, e_blank, e_fs, e_rgb, e_uf, e_pops;
        e_rinc = 0; e_hs = 0; e_blank = 0; e_fs = 0; e_rgb = 0; e_uf = 0; e_pops = 0;
        pops = 0; fs_t = -1;
        for (int k = 0; k < 40 * HTOTAL + 100; k++) begin
            x = k % HTOTAL;
            y = k / HTOTAL;
            act  = (x < HDISP) && (y < VDISP);
            hole = (y == 5) && (x >= 10) && (x <= 12);
            ehs  = !((x >= 200) && (x < 248));
            efs  = (x == 0) && (y == 0);
            euf  = (y > 5) || ((y == 5) && (x >= 10));
            if (act && !hole)
                erg = 24'(14400 + y * HDISP + x - (((y > 5) || ((y == 5) && (x > 12))) ? 3 : 0));
            else
                erg = 24'd0;
            fifo_rempty = hole;
            step(wp);
            if (wp !== (act && !hole)) e_rinc++;
            if (vga_hs !== ehs)        e_hs++;
            if (vga_blank !== act)     e_blank++;
            if (frame_start !== efs)   e_fs++;
            if (vga_rgb !== erg)       e_rgb++;
            if (underflow !== euf)     e_uf++;
            if (frame_start === 1'b1 && fs_t < 0) fs_t = FRAME + k;
            if (wp) pops++;
            if (x == HTOTAL - 1) begin
                if (pops != ((y == 5) ? HDISP - 3 : HDISP)) e_pops++;
                pops = 0;
            end
        end
        fifo_rempty = 1'b0;
        n_checks++; if (e_rinc != 0)  begin n_fail++; $display("FAIL uf_rinc: %0d wrong cycles, expected 0", e_rinc); end
        n_checks++; if (e_rgb != 0)   begin n_fail++; $display("FAIL uf_rgb: %0d wrong pixels, expected 0", e_rgb); end
        n_checks++; if (e_uf != 0)    begin n_fail++; $display("FAIL uf_flag: %0d wrong cycles, expected 0", e_uf); end
        n_checks++; if (e_hs != 0 || e_blank != 0) begin n_fail++; $display("FAIL uf_timing: hs %0d blank %0d wrong cycles, expected 0", e_hs, e_blank); end
        n_checks++; if (e_fs != 0)    begin n_fail++; $display("FAIL uf_frame_start: %0d wrong cycles, expected 0", e_fs); end
        n_checks++; if (e_pops != 0)  begin n_fail++; $display("FAIL uf_line_pops: %0d lines wrong, expected 0", e_pops); end
        n_checks++; if (fs_t != FRAME) begin n_fail++; $display("FAIL frame_period: frame_start at t=%0d, expected %0d", fs_t, FRAME); end
    endtask

    // Raster is now at (100,40) with underflow already set.
    task automatic test_mid_reset();
        logic        wp;
        logic [23:0] d;
        int          bad;
        pixel_rst = 1'b1;
        #1;
        n_checks++; if (vga_hs !== 1'b1)      begin n_fail++; $display("FAIL mid_hs: got %b, expected 1", vga_hs); end
        n_checks++; if (vga_vs !== 1'b1)      begin n_fail++; $display("FAIL mid_vs: got %b, expected 1", vga_vs); end
        n_checks++; if (vga_blank !== 1'b0)   begin n_fail++; $display("FAIL mid_blank: got %b, expected 0", vga_blank); end
        n_checks++; if (vga_rgb !== 24'd0)    begin n_fail++; $display("FAIL mid_rgb: got %0h, expected 0", vga_rgb); end
        n_checks++; if (pixel_x !== 8'd0)     begin n_fail++; $display("FAIL mid_x: got %0d, expected 0", pixel_x); end
        n_checks++; if (pixel_y !== 7'd0)     begin n_fail++; $display("FAIL mid_y: got %0d, expected 0", pixel_y); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_fs: got %b, expected 0", frame_start); end
        n_checks++; if (underflow !== 1'b0)   begin n_fail++; $display("FAIL mid_uf: got %b, expected 0", underflow); end
        n_checks++; if (fifo_rinc !== 1'b0)   begin n_fail++; $display("FAIL mid_rinc: got %b, expected 0", fifo_rinc); end
        fifo_rfull = 1'b0;
        repeat (2) @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(wp);
            if (wp !== 1'b0 || vga_blank !== 1'b0 || vga_hs !== 1'b1 || vga_vs !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rewait_idle: %0d cycles not idle, expected 0", bad); end
        fifo_rfull = 1'b1;
        step(wp);
        fifo_rfull = 1'b0;
        d = fifo_rdata;
        step(wp);
        n_checks++; if (wp !== 1'b1)          begin n_fail++; $display("FAIL restart_pop: got %b, expected 1", wp); end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL restart_fs: got %b, expected 1", frame_start); end
        n_checks++; if (vga_blank !== 1'b1)   begin n_fail++; $display("FAIL restart_blank: got %b, expected 1", vga_blank); end
        n_checks++; if (pixel_x !== 8'd0 || pixel_y !== 7'd0) begin n_fail++; $display("FAIL restart_xy: got (%0d,%0d), expected (0,0)", pixel_x, pixel_y); end
        n_checks++; if (vga_rgb !== d)        begin n_fail++; $display("FAIL restart_rgb: got %0h, expected %0h", vga_rgb, d); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_underflow();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
